// File: rtl/param_aggregator_if.sv
// ---------------------------------------------------------------------------
// param_aggregator_if
//   Bundles the sender (dequeue-style FIFO read side), receiver (enqueue-style
//   wide consumer) and runtime control signals of param_aggregator.
//
//   Signals
//     sender_data         word at the sender head
//     sender_empty_n      sender holds a word
//     sender_deq          aggregator pops the sender this cycle
//     receiver_data       packed group, lane k = bits [(k+1)*DW-1 : k*DW]
//     receiver_mask       lane-valid bits for receiver_data
//     receiver_full_n     receiver can accept
//     receiver_enq        aggregator pushes receiver_data/mask this cycle
//     change_fetch_width  1-cycle pulse requesting a new group size
//     input_fetch_width   requested group size (legal range 1..MAX_FETCH_WIDTH)
//     flush               1-cycle pulse requesting emission of a partial group
//     cfg_err             sticky out-of-range request flag
//
//   Modports
//     master  the surrounding environment (drives sender/receiver/control)
//     slave   the aggregator itself
// ---------------------------------------------------------------------------
interface param_aggregator_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_FETCH_WIDTH = 6
);
  localparam int CW = $clog2(MAX_FETCH_WIDTH + 1);

  logic [DATA_WIDTH-1:0]                 sender_data;
  logic                                  sender_empty_n;
  logic                                  sender_deq;
  logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data;
  logic [MAX_FETCH_WIDTH-1:0]            receiver_mask;
  logic                                  receiver_full_n;
  logic                                  receiver_enq;
  logic                                  change_fetch_width;
  logic [CW-1:0]                         input_fetch_width;
  logic                                  flush;
  logic                                  cfg_err;

  modport master (
    output sender_data, sender_empty_n, receiver_full_n,
    output change_fetch_width, input_fetch_width, flush,
    input  sender_deq, receiver_data, receiver_mask, receiver_enq, cfg_err
  );

  modport slave (
    input  sender_data, sender_empty_n, receiver_full_n,
    input  change_fetch_width, input_fetch_width, flush,
    output sender_deq, receiver_data, receiver_mask, receiver_enq, cfg_err
  );
endinterface

// File: rtl/param_aggregator.sv
// ---------------------------------------------------------------------------
// param_aggregator
//   Packs a stream of DATA_WIDTH words popped from a FIFO read side into
//   groups of up to MAX_FETCH_WIDTH words and presents each group as one wide
//   word (plus lane-valid mask) to an enqueue-style receiver. The group size
//   can be changed at runtime, a flush pulse emits a partial group, and a
//   one-entry output register lets accumulation continue while the receiver
//   applies back-pressure.
//
//   Ports
//     clk   single clock
//     rst   asynchronous, active-high reset
//     bus   param_aggregator_if.slave: sender, receiver and control signals
//           (see the interface header for the individual signals)
// ---------------------------------------------------------------------------
module param_aggregator #(
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_FETCH_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  param_aggregator_if.slave     bus
);

  localparam int CW = $clog2(MAX_FETCH_WIDTH + 1);

  typedef enum logic {
    EMPTY,
    FILL
  } state_e;

  // Registered state
  state_e                                     state_q;
  logic [CW-1:0]                              count_q;
  logic [CW-1:0]                              fw_q;
  logic                                       pend_valid_q;
  logic [CW-1:0]                              pend_fw_q;
  logic                                       flush_pend_q;
  logic [MAX_FETCH_WIDTH-1:0][DATA_WIDTH-1:0] acc_q;
  logic                                       out_valid_q;
  logic [MAX_FETCH_WIDTH-1:0][DATA_WIDTH-1:0] out_data_q;
  logic [MAX_FETCH_WIDTH-1:0]                 out_mask_q;
  logic                                       cfg_err_q;

  // Combinational handshake / control
  logic                                       last_slot;
  logic                                       accept;
  logic                                       deq;
  logic                                       enq;
  logic                                       out_free;
  logic [CW-1:0]                              n_words;
  logic                                       grp_done;
  logic                                       flush_req;
  logic                                       has_words;
  logic                                       flush_go;
  logic                                       load;
  logic                                       apply_pend;
  logic                                       req_ok;
  logic [MAX_FETCH_WIDTH-1:0][DATA_WIDTH-1:0] load_data;
  logic [MAX_FETCH_WIDTH-1:0]                 load_mask;

  always_comb begin
    last_slot = (count_q == CW'(fw_q - CW'(1)));
    out_free  = !out_valid_q || bus.receiver_full_n;

    // Only the final word of a group needs a free output register; earlier
    // words keep landing in the accumulator while the receiver is stalled.
    accept    = !(last_slot && out_valid_q && !bus.receiver_full_n);
    deq       = bus.sender_empty_n && accept;
    enq       = out_valid_q && bus.receiver_full_n;

    n_words   = CW'(count_q + CW'(deq));
    grp_done  = deq && last_slot;
    flush_req = bus.flush || flush_pend_q;
    has_words = (count_q != '0) || deq;
    flush_go  = flush_req && has_words && out_free;
    load      = grp_done || flush_go;

    // A word popped this cycle bypasses the accumulator straight into its
    // lane so a group can complete with no extra cycle of latency.
    load_data = '0;
    load_mask = '0;
    for (int k = 0; k < MAX_FETCH_WIDTH; k++) begin
      if (CW'(k) < n_words) begin
        load_mask[k] = 1'b1;
        if (deq && (CW'(k) == count_q)) begin
          load_data[k] = bus.sender_data;
        end else begin
          load_data[k] = acc_q[k];
        end
      end
    end

    // A pending size is only adopted between groups so the group in
    // progress always completes at the size it started with.
    apply_pend = pend_valid_q && (((state_q == EMPTY) && !deq) || load);
    req_ok     = (bus.input_fetch_width != '0) &&
                 (bus.input_fetch_width <= CW'(MAX_FETCH_WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      count_q      <= '0;
      fw_q         <= CW'(MAX_FETCH_WIDTH);
      pend_valid_q <= 1'b0;
      pend_fw_q    <= CW'(MAX_FETCH_WIDTH);
      flush_pend_q <= 1'b0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_mask_q   <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      // The output register may drain and reload in the same cycle.
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= load_data;
        out_mask_q  <= load_mask;
        count_q     <= '0;
        state_q     <= EMPTY;
      end else begin
        if (enq) begin
          out_valid_q <= 1'b0;
        end
        if (deq) begin
          acc_q[count_q] <= bus.sender_data;
          count_q        <= CW'(count_q + CW'(1));
          state_q        <= FILL;
        end
      end

      // A flush that finds the output register blocked waits for it; a
      // flush with nothing to emit is dropped.
      flush_pend_q <= flush_req && has_words && !out_free;

      if (apply_pend) begin
        fw_q         <= pend_fw_q;
        pend_valid_q <= 1'b0;
      end

      // Placed after the apply so that a request arriving in the same cycle
      // remains pending (newest request wins).
      if (bus.change_fetch_width) begin
        if (req_ok) begin
          pend_valid_q <= 1'b1;
          pend_fw_q    <= bus.input_fetch_width;
        end else begin
          cfg_err_q    <= 1'b1;
        end
      end
    end
  end

  assign bus.sender_deq    = deq;
  assign bus.receiver_enq  = enq;
  assign bus.receiver_data = out_data_q;
  assign bus.receiver_mask = out_mask_q;
  assign bus.cfg_err       = cfg_err_q;

endmodule
